// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
//
// Data-memory responder for the pipeline's dmem port. It stands in for the data
// cache during bring-up. It accepts one read or write request at a time, waits
// a fixed number of cycles (LATENCY), and then completes the request with a
// single-cycle dmem_resp pulse. Storage is word-wide, and writes are merged
// lane by lane using the byte enables.
//
// Parameters
//   DEPTH_WORDS  storage depth in 32-bit words (power of two)
//   BASE_ADDR    byte address that maps to word 0
//   LATENCY      cycles from request acceptance to dmem_resp (>= 1)
//
// Ports
//   clk               clock, rising edge
//   rst               asynchronous, active-low reset
//   dmem_read         read request, held by the requester until dmem_resp
//   dmem_write        write request, held by the requester until dmem_resp
//                     (it wins when both requests are high)
//   dmem_address      byte address; bits [1:0] are ignored
//   dmem_wdata        write data, lanes aligned to a word boundary
//   dmem_byte_enable  write lane enables; bit i enables wdata[8i+7:8i]
//   dmem_rdata        read data (the pre-write word for writes); holds until
//                     the next response
//   dmem_resp         one-cycle completion pulse
//   dmem_busy         high while a request is in flight
//   dmem_err          out-of-range flag, valid with dmem_resp
//                     (only present when DMEM_OOR_ERR_EN is defined)
//
// Configuration macro
//   DMEM_OOR_ERR_EN   When defined, addresses outside the mapped window complete
//                     with dmem_err=1 and dmem_rdata=0, and they never write
//                     storage. When undefined, the word index wraps modulo
//                     DEPTH_WORDS.
// -----------------------------------------------------------------------------
module dmem_responder #(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0,
    parameter int          LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dmem_read,
    input  logic        dmem_write,
    input  logic [31:0] dmem_address,
    input  logic [31:0] dmem_wdata,
    input  logic [3:0]  dmem_byte_enable,
    output logic [31:0] dmem_rdata,
    output logic        dmem_resp,
    output logic        dmem_busy
`ifdef DMEM_OOR_ERR_EN
    ,
    output logic        dmem_err
`endif
);

    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    // Final value of the WAIT counter. It is only used when LATENCY > 1.
    localparam logic [31:0] LAST_CNT = (LATENCY > 1) ? 32'(LATENCY - 2) : 32'd0;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t            state;
    logic [31:0]       counter;

    logic [31:0]       mem [0:DEPTH_WORDS-1];

    logic [IDX_W-1:0]  req_idx;
    logic [31:0]       req_wdata;
    logic [3:0]        req_be;
    logic              req_write;
    logic              req_oor;

    logic [31:0]       byte_offset;
    logic [29:0]       word_offset;
    logic [IDX_W-1:0]  in_idx;
    logic              in_oor;
    logic              unused_bits;

    // Word index relative to BASE_ADDR. The subtract is unsigned, so an
    // address below the base wraps to a huge offset. That offset falls out of
    // range when range checking is enabled.
    assign byte_offset = dmem_address - BASE_ADDR;
    assign word_offset = byte_offset[31:2];
    assign in_idx      = word_offset[IDX_W-1:0];

`ifdef DMEM_OOR_ERR_EN
    assign in_oor = (dmem_address < BASE_ADDR) || (word_offset >= 30'(DEPTH_WORDS));
`else
    assign in_oor = 1'b0;
`endif

    assign unused_bits = ^{byte_offset[1:0], word_offset[29:IDX_W]};

    // Request FSM. All outputs are registered. A request is sampled only in
    // IDLE, so the requester may keep its request asserted through dmem_resp.
    // A request that is still asserted in the following IDLE cycle is treated
    // as the next transaction.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            counter    <= 32'd0;
            dmem_resp  <= 1'b0;
            dmem_busy  <= 1'b0;
            dmem_rdata <= 32'd0;
            req_idx    <= '0;
            req_wdata  <= 32'd0;
            req_be     <= 4'd0;
            req_write  <= 1'b0;
            req_oor    <= 1'b0;
`ifdef DMEM_OOR_ERR_EN
            dmem_err   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    dmem_resp <= 1'b0;
                    if (dmem_read || dmem_write) begin
                        req_idx   <= in_idx;
                        req_wdata <= dmem_wdata;
                        req_be    <= dmem_byte_enable;
                        req_write <= dmem_write;
                        req_oor   <= in_oor;
                        counter   <= 32'd0;
                        dmem_busy <= 1'b1;
                        if (LATENCY == 1) begin
                            // Skip WAIT. The read uses the live index
                            // because the latched copy is not valid yet.
                            state      <= RESP;
                            dmem_resp  <= 1'b1;
                            dmem_rdata <= in_oor ? 32'd0 : mem[in_idx];
`ifdef DMEM_OOR_ERR_EN
                            dmem_err   <= in_oor;
`endif
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (counter == LAST_CNT) begin
                        state      <= RESP;
                        dmem_resp  <= 1'b1;
                        dmem_rdata <= req_oor ? 32'd0 : mem[req_idx];
`ifdef DMEM_OOR_ERR_EN
                        dmem_err   <= req_oor;
`endif
                    end else begin
                        counter <= counter + 32'd1;
                    end
                end
                RESP: begin
                    state     <= IDLE;
                    dmem_resp <= 1'b0;
                    dmem_busy <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    dmem_resp <= 1'b0;
                    dmem_busy <= 1'b0;
                end
            endcase
        end
    end

    // The write commits on the edge that leaves RESP. Because of this,
    // dmem_rdata for a write response shows the pre-write word. A reset during
    // the request forces the FSM to IDLE, so an aborted write never reaches
    // storage. Storage itself is not reset.
    always_ff @(posedge clk) begin
        if (state == RESP && req_write && !req_oor) begin
            for (int i = 0; i < 4; i++) begin
                if (req_be[i]) begin
                    mem[req_idx][8*i +: 8] <= req_wdata[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_dmem_responder
//
// Directed testbench for dmem_responder. It uses two instances: dut_a with
// LATENCY=2 and dut_b with LATENCY=1. Both use DEPTH_WORDS=1024 and
// BASE_ADDR=0. Expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_dmem_responder;

    logic        clk;
    logic        rst;

    logic        a_read, a_write;
    logic [31:0] a_addr, a_wdata;
    logic [3:0]  a_be;
    logic [31:0] a_rdata;
    logic        a_resp, a_busy;

    logic        b_read, b_write;
    logic [31:0] b_addr, b_wdata;
    logic [3:0]  b_be;
    logic [31:0] b_rdata;
    logic        b_resp, b_busy;

`ifdef DMEM_OOR_ERR_EN
    logic        a_err, b_err;
`endif

    int total = 0;
    int bad   = 0;

    int          cycles;
    logic [31:0] rdata;
    logic        err;

    dmem_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .LATENCY(2)) dut_a (
        .clk              (clk),
        .rst              (rst),
        .dmem_read        (a_read),
        .dmem_write       (a_write),
        .dmem_address     (a_addr),
        .dmem_wdata       (a_wdata),
        .dmem_byte_enable (a_be),
        .dmem_rdata       (a_rdata),
        .dmem_resp        (a_resp),
        .dmem_busy        (a_busy)
`ifdef DMEM_OOR_ERR_EN
        ,
        .dmem_err         (a_err)
`endif
    );

    dmem_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .LATENCY(1)) dut_b (
        .clk              (clk),
        .rst              (rst),
        .dmem_read        (b_read),
        .dmem_write       (b_write),
        .dmem_address     (b_addr),
        .dmem_wdata       (b_wdata),
        .dmem_byte_enable (b_be),
        .dmem_rdata       (b_rdata),
        .dmem_resp        (b_resp),
        .dmem_busy        (b_busy)
`ifdef DMEM_OOR_ERR_EN
        ,
        .dmem_err         (b_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its expected value. Every call
    // counts as one comparison.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Drive one request on dut_a (sel=0) or dut_b (sel=1) at a falling edge.
    // Then count falling edges until dmem_resp, with a cycle budget, and drop
    // the request in the response cycle. The returned count equals the DUT's
    // LATENCY.
    task automatic applyStimulus(input bit sel, input logic wr, input logic rd,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [3:0] be, output int n,
                                 output logic [31:0] rd_o, output logic err_o);
        logic seen;
        @(negedge clk);
        if (!sel) begin
            a_write = wr; a_read = rd; a_addr = addr; a_wdata = wdata; a_be = be;
        end else begin
            b_write = wr; b_read = rd; b_addr = addr; b_wdata = wdata; b_be = be;
        end
        n = 0;
        seen = 1'b0;
        while (!seen && n < 20) begin
            @(negedge clk);
            n++;
            seen = sel ? b_resp : a_resp;
        end
        if (!seen) checkOutput("resp_timeout", {31'd0, seen}, 32'd1);
        rd_o  = sel ? b_rdata : a_rdata;
        err_o = 1'b0;
`ifdef DMEM_OOR_ERR_EN
        err_o = sel ? b_err : a_err;
`endif
        a_write = 1'b0; a_read = 1'b0;
        b_write = 1'b0; b_read = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        a_read = 1'b0; a_write = 1'b0; a_addr = 32'd0; a_wdata = 32'd0; a_be = 4'd0;
        b_read = 1'b0; b_write = 1'b0; b_addr = 32'd0; b_wdata = 32'd0; b_be = 4'd0;

        // Reset state
        #1;
        checkOutput("rst_a_resp",  {31'd0, a_resp}, 32'd0);
        checkOutput("rst_a_busy",  {31'd0, a_busy}, 32'd0);
        checkOutput("rst_a_rdata", a_rdata, 32'd0);
        checkOutput("rst_b_busy",  {31'd0, b_busy}, 32'd0);
`ifdef DMEM_OOR_ERR_EN
        checkOutput("rst_a_err",   {31'd0, a_err}, 32'd0);
`endif
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        $display("[TB] reset released");

        // Test 1: a reset in the middle of WAIT drops the write
        applyStimulus(0, 1'b1, 1'b0, 32'h10, 32'h01010101, 4'hF, cycles, rdata, err);
        @(negedge clk);
        a_write = 1'b1; a_addr = 32'h10; a_wdata = 32'hDEADBEEF; a_be = 4'hF;
        @(negedge clk);
        checkOutput("t1_busy_in_wait", {31'd0, a_busy}, 32'd1);
        rst = 1'b0;
        a_write = 1'b0;
        #1;
        checkOutput("t1_resp_after_rst",  {31'd0, a_resp}, 32'd0);
        checkOutput("t1_busy_after_rst",  {31'd0, a_busy}, 32'd0);
        checkOutput("t1_rdata_after_rst", a_rdata, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        applyStimulus(0, 1'b0, 1'b1, 32'h10, 32'h0, 4'h0, cycles, rdata, err);
        checkOutput("t1_old_word", rdata, 32'h01010101);

        // Test 2: full-word write and read, LATENCY=2
        applyStimulus(0, 1'b1, 1'b0, 32'h20, 32'h11223344, 4'hF, cycles, rdata, err);
        checkOutput("t2_wr_latency", 32'(cycles), 32'd2);
        applyStimulus(0, 1'b0, 1'b1, 32'h20, 32'h0, 4'h0, cycles, rdata, err);
        checkOutput("t2_rd_latency", 32'(cycles), 32'd2);
        checkOutput("t2_rd_data", rdata, 32'h11223344);
`ifdef DMEM_OOR_ERR_EN
        checkOutput("t2_err_in_range", {31'd0, err}, 32'd0);
`endif

        // Test 3: byte-lane merge and an all-lanes-disabled write
        applyStimulus(0, 1'b1, 1'b0, 32'h30, 32'hAABBCCDD, 4'hF, cycles, rdata, err);
        applyStimulus(0, 1'b1, 1'b0, 32'h30, 32'h00EE0000, 4'b0100, cycles, rdata, err);
        checkOutput("t3_prewrite_rdata", rdata, 32'hAABBCCDD);
        applyStimulus(0, 1'b0, 1'b1, 32'h30, 32'h0, 4'h0, cycles, rdata, err);
        checkOutput("t3_merged", rdata, 32'hAAEECCDD);
        applyStimulus(0, 1'b1, 1'b0, 32'h30, 32'hFFFFFFFF, 4'b0000, cycles, rdata, err);
        checkOutput("t3_be0_latency", 32'(cycles), 32'd2);
        applyStimulus(0, 1'b0, 1'b1, 32'h30, 32'h0, 4'h0, cycles, rdata, err);
        checkOutput("t3_be0_unchanged", rdata, 32'hAAEECCDD);

        // Test 4: read and write both high is treated as a write
        applyStimulus(0, 1'b1, 1'b0, 32'h40, 32'h12345678, 4'hF, cycles, rdata, err);
        applyStimulus(0, 1'b1, 1'b1, 32'h40, 32'h5A5A5A5A, 4'hF, cycles, rdata, err);
        checkOutput("t4_old_word", rdata, 32'h12345678);
        applyStimulus(0, 1'b0, 1'b1, 32'h40, 32'h0, 4'h0, cycles, rdata, err);
        checkOutput("t4_new_word", rdata, 32'h5A5A5A5A);

        // Test 5: LATENCY=1 with the read held across the response
        applyStimulus(1, 1'b1, 1'b0, 32'h60, 32'h600D600D, 4'hF, cycles, rdata, err);
        checkOutput("t5_wr_latency", 32'(cycles), 32'd1);
        @(negedge clk);
        b_read = 1'b1; b_addr = 32'h60;
        @(negedge clk);
        checkOutput("t5_resp_1",  {31'd0, b_resp}, 32'd1);
        checkOutput("t5_busy_1",  {31'd0, b_busy}, 32'd1);
        checkOutput("t5_rdata_1", b_rdata, 32'h600D600D);
        @(negedge clk);
        checkOutput("t5_resp_2",  {31'd0, b_resp}, 32'd0);
        checkOutput("t5_busy_2",  {31'd0, b_busy}, 32'd0);
        @(negedge clk);
        checkOutput("t5_resp_3",  {31'd0, b_resp}, 32'd1);
        checkOutput("t5_busy_3",  {31'd0, b_busy}, 32'd1);
        checkOutput("t5_rdata_3", b_rdata, 32'h600D600D);
        b_read = 1'b0;
        @(negedge clk);
        checkOutput("t5_resp_4",  {31'd0, b_resp}, 32'd0);

        // Test 6: index 1024 is out of range, or wraps to word 0
        applyStimulus(0, 1'b1, 1'b0, 32'h0, 32'h0BADF00D, 4'hF, cycles, rdata, err);
        applyStimulus(0, 1'b0, 1'b1, 32'h1000, 32'h0, 4'h0, cycles, rdata, err);
`ifdef DMEM_OOR_ERR_EN
        checkOutput("t6_err",   {31'd0, err}, 32'd1);
        checkOutput("t6_rdata", rdata, 32'h0);
`else
        checkOutput("t6_wrap_rdata", rdata, 32'h0BADF00D);
`endif
        checkOutput("t6_latency", 32'(cycles), 32'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
